// File: rtl/pcm_to_i2s.sv
// Parallel PCM pair to Philips I2S transmitter; generates sck/ws internally from clk.
// Define PCM_TX_HOLD_LAST_EN to repeat the last pair on underrun instead of sending silence.
module pcm_to_i2s #(
  parameter int NUMBER_OF_BITS = 8,
  parameter int SLOT_BITS      = 32,
  parameter int BCLK_DIV       = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic [NUMBER_OF_BITS-1:0] left_in,
  input  logic [NUMBER_OF_BITS-1:0] right_in,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic                      sck,
  output logic                      ws,
  output logic                      sd,
  output logic                      frame_start,
  output logic                      underrun
);

  localparam int FRAME_BITS = 2 * SLOT_BITS;
  localparam int B_W        = $clog2(FRAME_BITS);
  localparam int DIV_W      = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
  localparam logic [B_W-1:0]   B_LAST   = B_W'(FRAME_BITS - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t                    state_q, state_d;
  logic [DIV_W-1:0]          div_q, div_d;
  logic [B_W-1:0]            b_q, b_d, b_inc;
  logic                      sck_q, sck_d, ws_q, ws_d, sd_q, sd_d;
  logic                      fs_q, fs_d, ur_q, ur_d, rdy_q, rdy_d;
  logic                      full_q, full_d;
  logic [NUMBER_OF_BITS-1:0] hold_l_q, hold_l_d, hold_r_q, hold_r_d;
  logic [NUMBER_OF_BITS-1:0] frame_l_q, frame_l_d, frame_r_q, frame_r_d;
  logic [NUMBER_OF_BITS-1:0] slot_word;
  logic                      fall_tick, load, xfer;
  int                        w_pos, q_pos, o_pos;

  assign in_ready    = rdy_q;
  assign sck         = sck_q;
  assign ws          = ws_q;
  assign sd          = sd_q;
  assign frame_start = fs_q;
  assign underrun    = ur_q;

  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    b_d       = b_q;
    sck_d     = sck_q;
    ws_d      = ws_q;
    sd_d      = sd_q;
    fs_d      = 1'b0;
    ur_d      = 1'b0;
    full_d    = full_q;
    hold_l_d  = hold_l_q;
    hold_r_d  = hold_r_q;
    frame_l_d = frame_l_q;
    frame_r_d = frame_r_q;
    slot_word = '0;
    fall_tick = 1'b0;
    load      = 1'b0;
    xfer      = in_valid && rdy_q;
    w_pos     = 0;
    q_pos     = 0;
    o_pos     = 0;
    b_inc     = (b_q == B_LAST) ? '0 : b_q + B_W'(1);

    case (state_q)
      IDLE: begin
        div_d = '0;
        b_d   = '0;
        sck_d = 1'b0;
        ws_d  = 1'b0;
        sd_d  = 1'b0;
        if (enable) state_d = RUN;
      end
      RUN: begin
        if (!enable) begin
          state_d = IDLE;
          div_d   = '0;
          b_d     = '0;
          sck_d   = 1'b0;
          ws_d    = 1'b0;
          sd_d    = 1'b0;
        end else if (div_q == DIV_LAST) begin
          div_d     = '0;
          sck_d     = !sck_q;
          fall_tick = sck_q;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (fall_tick) begin
      b_d  = b_inc;
      load = (b_inc == B_W'(1));
    end

    // Load uses the pre-handshake holding state; a same-cycle transfer lands in the next frame.
    if (load) begin
      fs_d = 1'b1;
      if (full_q) begin
        frame_l_d = hold_l_q;
        frame_r_d = hold_r_q;
        full_d    = 1'b0;
      end else begin
        ur_d = 1'b1;
`ifdef PCM_TX_HOLD_LAST_EN
        frame_l_d = frame_l_q;
        frame_r_d = frame_r_q;
`else
        frame_l_d = '0;
        frame_r_d = '0;
`endif
      end
    end

    if (xfer) begin
      hold_l_d = left_in;
      hold_r_d = right_in;
      full_d   = 1'b1;
    end

    rdy_d = !full_d;

    // ws and sd come from the new bit position; at b=1 sd sees the frame being loaded.
    if (fall_tick) begin
      w_pos     = (b_inc == B_LAST) ? 0 : 32'(b_inc) + 1;
      ws_d      = (w_pos >= SLOT_BITS);
      q_pos     = (b_inc == '0) ? FRAME_BITS - 1 : 32'(b_inc) - 1;
      slot_word = (q_pos >= SLOT_BITS) ? frame_r_d : frame_l_d;
      o_pos     = (q_pos >= SLOT_BITS) ? q_pos - SLOT_BITS : q_pos;
      sd_d      = 1'b0;
      for (int unsigned i = 0; i < NUMBER_OF_BITS; i++) begin
        if (o_pos == int'(i)) sd_d = slot_word[NUMBER_OF_BITS-1-i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      div_q     <= '0;
      b_q       <= '0;
      sck_q     <= 1'b0;
      ws_q      <= 1'b0;
      sd_q      <= 1'b0;
      fs_q      <= 1'b0;
      ur_q      <= 1'b0;
      rdy_q     <= 1'b0;
      full_q    <= 1'b0;
      hold_l_q  <= '0;
      hold_r_q  <= '0;
      frame_l_q <= '0;
      frame_r_q <= '0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      b_q       <= b_d;
      sck_q     <= sck_d;
      ws_q      <= ws_d;
      sd_q      <= sd_d;
      fs_q      <= fs_d;
      ur_q      <= ur_d;
      rdy_q     <= rdy_d;
      full_q    <= full_d;
      hold_l_q  <= hold_l_d;
      hold_r_q  <= hold_r_d;
      frame_l_q <= frame_l_d;
      frame_r_q <= frame_r_d;
    end
  end

endmodule

// File: tb/tb_pcm_to_i2s.sv
// Directed bench for pcm_to_i2s: reset, framing, underrun, backpressure, divider, mid-frame stop/reset, loopback.
module tb_pcm_to_i2s;

  logic       clk = 1'b0;
  logic       reset, enable, in_valid, enable3, in_valid3;
  logic [7:0] left_in, right_in;
  logic       in_ready, sck, ws, sd, frame_start, underrun;
  logic       in_ready3, sck3, ws3, sd3, fs3, ur3;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [63:0] WS_EXP = 64'h7FFF_FFFF_8000_0000;

  always #5 clk = ~clk;

  pcm_to_i2s #(.NUMBER_OF_BITS(8), .SLOT_BITS(32), .BCLK_DIV(1)) dut (
    .clk(clk), .reset(reset), .enable(enable), .left_in(left_in), .right_in(right_in),
    .in_valid(in_valid), .in_ready(in_ready), .sck(sck), .ws(ws), .sd(sd),
    .frame_start(frame_start), .underrun(underrun)
  );

  pcm_to_i2s #(.NUMBER_OF_BITS(8), .SLOT_BITS(32), .BCLK_DIV(3)) dut3 (
    .clk(clk), .reset(reset), .enable(enable3), .left_in(left_in), .right_in(right_in),
    .in_valid(in_valid3), .in_ready(in_ready3), .sck(sck3), .ws(ws3), .sd(sd3),
    .frame_start(fs3), .underrun(ur3)
  );

  // Minimal I2S receiver on the loopback: MSB arrives two sck rises after a ws edge.
  logic       rx_ws_last = 1'b0;
  logic       rx_ch = 1'b0;
  int         rx_cnt = 0;
  int         rx_cur;
  logic [7:0] rx_sh = '0, rx_l = '0, rx_r = '0;
  assign rx_cur = (ws != rx_ws_last) ? 0 : rx_cnt + 1;
  always @(posedge sck) begin
    rx_ws_last <= ws;
    rx_cnt     <= rx_cur;
    if (ws != rx_ws_last) rx_ch <= ws;
    if (rx_cur >= 2 && rx_cur <= 9) rx_sh <= {rx_sh[6:0], sd};
    if (rx_cur == 9) begin
      if (rx_ch) rx_r <= {rx_sh[6:0], sd};
      else       rx_l <= {rx_sh[6:0], sd};
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_fall();
    logic prev;
    bit   seen;
    seen = 1'b0;
    for (int n = 0; n < 400 && !seen; n++) begin
      prev = sck;
      tick();
      if (prev && !sck) seen = 1'b1;
    end
    check("fall_seen", 64'(seen), 64'd1);
  endtask

  function automatic logic [63:0] exp_vec(input logic [7:0] l, input logic [7:0] r);
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < 8; i++) begin
      v[1+i]  = l[7-i];
      v[33+i] = r[7-i];
    end
    return v;
  endfunction

  // Called at the b=1 sample; returns at the b=1 sample of the following frame.
  task automatic capture_frame(output logic [63:0] sdv, output logic [63:0] wsv,
                               output logic fs_n, output logic ur_n);
    sdv = '0;
    wsv = '0;
    sdv[1] = sd;
    wsv[1] = ws;
    for (int i = 2; i <= 64; i++) begin
      wait_fall();
      sdv[i%64] = sd;
      wsv[i%64] = ws;
    end
    wait_fall();
    fs_n = frame_start;
    ur_n = underrun;
  endtask

  task automatic push(input logic [7:0] l, input logic [7:0] r, input string tag);
    left_in  = l;
    right_in = r;
    in_valid = 1'b1;
    for (int n = 0; n < 400 && !in_ready; n++) tick();
    check({tag, "_ready_wait"}, 64'(in_ready), 64'd1);
    tick();
    check({tag, "_ready_drop"}, 64'(in_ready), 64'd0);
    in_valid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [63:0] sdv, wsv, under_vec;
    logic        fs_n, ur_n, prev;
    int          n;
    bit          seen;
    int          hi_min, hi_max, lo_min, lo_max, run, changes, bad;
    logic        p_sck, p_sd, p_ws;
    logic [7:0]  pl[3];
    logic [7:0]  pr[3];

    pl = '{8'hA5, 8'h96, 8'h0F};
    pr = '{8'h3C, 8'h71, 8'hE8};
`ifdef PCM_TX_HOLD_LAST_EN
    under_vec = exp_vec(8'hA5, 8'h3C);
`else
    under_vec = '0;
`endif

    // Reset with valid/enable asserted
    reset = 1'b1; enable = 1'b1; in_valid = 1'b1; left_in = 8'h11; right_in = 8'h22;
    enable3 = 1'b0; in_valid3 = 1'b0;
    tick(); tick();
    check("rst_sck", 64'(sck), 0);
    check("rst_ws", 64'(ws), 0);
    check("rst_sd", 64'(sd), 0);
    check("rst_in_ready", 64'(in_ready), 0);
    check("rst_frame_start", 64'(frame_start), 0);
    check("rst_underrun", 64'(underrun), 0);

    reset = 1'b0; enable = 1'b0; left_in = 8'hA5; right_in = 8'h3C;
    tick();
    check("post_rst_ready", 64'(in_ready), 1);
    tick();
    in_valid = 1'b0;
    check("accept_drop", 64'(in_ready), 0);

    // Basic frame from the prefilled pair
    enable = 1'b1;
    n = 0; seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      prev = sck;
      tick();
      n++;
      if (prev && !sck) seen = 1'b1;
    end
    check("first_fall_clk", 64'(n), 3);
    check("f1_frame_start", 64'(frame_start), 1);
    check("f1_underrun", 64'(underrun), 0);
    check("f1_ready_rise", 64'(in_ready), 1);
    capture_frame(sdv, wsv, fs_n, ur_n);
    check("f1_sd", sdv, exp_vec(8'hA5, 8'h3C));
    check("f1_ws", wsv, WS_EXP);
    check("f2_frame_start", 64'(fs_n), 1);
    check("f2_underrun", 64'(ur_n), 1);

    // Underrun frame
    capture_frame(sdv, wsv, fs_n, ur_n);
    check("f2_sd_underrun", sdv, under_vec);
    check("f2_ws", wsv, WS_EXP);
    check("f3_underrun", 64'(ur_n), 1);

    // Backpressure: three pairs offered back to back
    fork
      begin
        for (int k = 0; k < 3; k++) push(pl[k], pr[k], "bp");
      end
      begin
        capture_frame(sdv, wsv, fs_n, ur_n);
        check("f3_sd_underrun", sdv, under_vec);
        for (int k = 0; k < 3; k++) begin
          check("bp_load_fs", 64'(fs_n), 1);
          check("bp_load_ur", 64'(ur_n), 0);
          check("bp_load_ready", 64'(in_ready), 1);
          capture_frame(sdv, wsv, fs_n, ur_n);
          check("bp_sd", sdv, exp_vec(pl[k], pr[k]));
          check("bp_ws", wsv, WS_EXP);
          if (k == 0) begin
            check("loop_left", 64'(rx_l), 64'hA5);
            check("loop_right", 64'(rx_r), 64'h3C);
          end
        end
        check("bp_tail_underrun", 64'(ur_n), 1);
      end
    join

    // Enable dropped at b=40 with a pair waiting
    push(8'h5A, 8'hC3, "q");
    for (int k = 0; k < 39; k++) wait_fall();
    check("b40_ws_high", 64'(ws), 1);
    enable = 1'b0;
    tick();
    check("stop_sck", 64'(sck), 0);
    check("stop_ws", 64'(ws), 0);
    check("stop_sd", 64'(sd), 0);
    check("stop_hold_kept", 64'(in_ready), 0);
    tick(); tick();
    enable = 1'b1;
    wait_fall();
    check("restart_fs", 64'(frame_start), 1);
    check("restart_ur", 64'(underrun), 0);
    capture_frame(sdv, wsv, fs_n, ur_n);
    check("restart_sd", sdv, exp_vec(8'h5A, 8'hC3));
    check("restart_next_ur", 64'(ur_n), 1);

    // Reset at b=40 clears the waiting pair
    push(8'h81, 8'h7E, "r");
    for (int k = 0; k < 39; k++) wait_fall();
    reset = 1'b1;
    tick();
    check("midrst_sck", 64'(sck), 0);
    check("midrst_ws", 64'(ws), 0);
    check("midrst_sd", 64'(sd), 0);
    check("midrst_ready", 64'(in_ready), 0);
    reset = 1'b0; enable = 1'b0;
    tick();
    check("midrst_hold_cleared", 64'(in_ready), 1);
    enable = 1'b1;
    wait_fall();
    check("midrst_fs", 64'(frame_start), 1);
    check("midrst_ur", 64'(underrun), 1);
    enable = 1'b0;
    tick();

    // Divider of 3 on the second instance
    left_in = 8'hA5; right_in = 8'h3C; in_valid3 = 1'b1;
    for (int k = 0; k < 10 && !in_ready3; k++) tick();
    tick();
    in_valid3 = 1'b0;
    check("div3_accept", 64'(in_ready3), 0);
    enable3 = 1'b1;
    n = 0;
    for (int k = 0; k < 20 && !sck3; k++) begin
      tick();
      n++;
    end
    check("div3_first_rise", 64'(n), 4);
    hi_min = 999; hi_max = 0; lo_min = 999; lo_max = 0;
    run = 1; changes = 0; bad = 0;
    p_sck = sck3; p_sd = sd3; p_ws = ws3;
    for (int k = 0; k < 500; k++) begin
      tick();
      if (sd3 != p_sd || ws3 != p_ws) begin
        changes++;
        if (!(p_sck && !sck3)) bad++;
      end
      if (sck3 == p_sck) run++;
      else begin
        if (p_sck) begin
          if (run < hi_min) hi_min = run;
          if (run > hi_max) hi_max = run;
        end else begin
          if (run < lo_min) lo_min = run;
          if (run > lo_max) lo_max = run;
        end
        run = 1;
      end
      p_sck = sck3; p_sd = sd3; p_ws = ws3;
    end
    check("div3_hi_min", 64'(hi_min), 3);
    check("div3_hi_max", 64'(hi_max), 3);
    check("div3_lo_min", 64'(lo_min), 3);
    check("div3_lo_max", 64'(lo_max), 3);
    check("div3_changes_seen", 64'(changes > 0), 1);
    check("div3_change_off_fall", 64'(bad), 0);
    enable3 = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pcm_to_i2s.md
Name: pcm_to_i2s

Overview:
- Transmit-side counterpart of the I2S-to-PCM receiver.
- Accepts parallel left/right PCM pairs through a valid/ready handshake into a one-entry holding register.
- Generates the bit clock (sck) and word select (ws) itself, and serialises each pair MSB-first in Philips I2S format (one-bit delay after each ws edge).
- Drives the beamformer output pins or an external DAC/codec, and loops back into the receiver for self-test.

Parameters:
- NUMBER_OF_BITS, 8: PCM sample width per channel. Must satisfy NUMBER_OF_BITS <= SLOT_BITS.
- SLOT_BITS, 32: sck periods per channel slot, so one frame is 2*SLOT_BITS sck periods. Must be >= 2.
- BCLK_DIV, 1: clk cycles per sck half-period. Must be >= 1.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high.
- enable  in  1  1 = run the serial interface; 0 = idle.
- left_in  in  NUMBER_OF_BITS  left sample, two's complement.
- right_in  in  NUMBER_OF_BITS  right sample.
- in_valid  in  1  left_in/right_in hold a valid pair.
- in_ready  out  1  holding register is empty.
- sck  out  1  serial bit clock.
- ws  out  1  word select: 0 = left, 1 = right.
- sd  out  1  serial data; changes only on sck falling edges.
- frame_start  out  1  one-clk pulse when a new frame is loaded.
- underrun  out  1  one-clk pulse when a frame is loaded with no pair available.

Behaviour:
- Reset (already decided): reset is synchronous, active-high; clock is clk. Reset applies on any cycle, including mid-frame.
  - Outputs after reset: sck=0, ws=0, sd=0, in_ready=0, frame_start=0, underrun=0.
  - Holding register and frame registers are cleared; state = IDLE.
  - in_ready goes to 1 on the first cycle after reset deasserts.
- Handshake:
  - A transfer occurs on a rising clk edge with in_valid && in_ready.
  - The pair is written to the holding register and in_ready drops the next cycle.
  - in_ready is independent of enable, so the holding register may be pre-filled while IDLE.
- States:
  - IDLE: sck, ws and sd held at 0. div_cnt=0, bit position b=0.
  - IDLE -> RUN when enable=1.
  - RUN -> IDLE on the first cycle enable=0: immediate stop with no frame completion. Outputs return to 0 next cycle; holding register contents are preserved.
- Divider (RUN only):
  - div_cnt counts 0..BCLK_DIV-1; at BCLK_DIV-1 sck toggles and div_cnt wraps.
  - A "fall tick" is a toggle where sck goes 1->0.
  - The first rising sck edge occurs BCLK_DIV cycles after entering RUN.
- Frame position: b in 0..2*SLOT_BITS-1 increments (mod 2*SLOT_BITS) on every fall tick. ws and sd update on the same edge from the new b. With S = SLOT_BITS:
  - ws = 1 iff ((b+1) mod 2S) >= S, i.e. ws leads the data by one bit.
  - q = (b-1) mod 2S. Slot is left if q < S, right otherwise. Offset o = q mod S.
  - sd = sample[NUMBER_OF_BITS-1-o] if o < NUMBER_OF_BITS, else 0 (zero padding).
- Frame load:
  - On the fall tick where b becomes 1, frame registers load from the holding register, the holding register empties, and frame_start pulses.
  - in_ready rises on the following cycle.
  - If the holding register is empty at that tick, the frame registers load 0 and underrun pulses together with frame_start.
  - A handshake in the same cycle as the load tick does not bypass: the load sees the old (empty) state and the new pair is used in the next frame.
- The receiver samples on sck rising edges, mid-bit; there is no combinational path from inputs to sck/ws/sd.

Optional Feature:
- Macro: PCM_TX_HOLD_LAST_EN.
- Defined: on underrun the frame registers keep their previous pair, so the last samples repeat. The underrun pulse still fires.
- Undefined: on underrun the frame registers load zeros, transmitting silence.

Test Plan:
- Reset: assert reset with in_valid=1 and enable=1 -> sck/ws/sd/in_ready/frame_start/underrun all 0. After deassert, in_ready=1 next cycle and one pair is accepted.
- Basic frame (N=8, S=32, DIV=1): prefill L=0xA5, R=0x3C, then enable.
  - sck period is 2 clk; first fall tick at clk 2 gives b=1 with frame_start pulse and no underrun.
  - sd for b=1..8 is 1,0,1,0,0,1,0,1; b=9..32 is 0.
  - ws rises at b=31; b=33..40 carry 0,0,1,1,1,1,0,0; ws falls at b=63.
- Underrun: no second pair -> at the next b=1, underrun=1 and frame_start=1.
  - Without macro: sd is all 0 for the frame.
  - With PCM_TX_HOLD_LAST_EN: sd repeats 0xA5/0x3C.
- Backpressure: in_valid held high with 3 distinct pairs -> in_ready=0 after each accept, reasserting one cycle after each b=1 load tick. Frames carry the pairs in order with no loss or duplication.
- Divider (DIV=3): sck is 3 clk high / 3 clk low; sd and ws change only on cycles where sck falls.
- Mid-frame events:
  - Reset at b=40: all outputs 0 next cycle and the holding register is cleared.
  - enable dropped at b=40: outputs 0 and the prefilled holding pair survives. Re-enable -> that pair is sent at b=1 of the new frame.
  - Loopback into the I2S receiver recovers L=0xA5, R=0x3C.
